// File: rtl/dac_stream_if.sv
// rtl/dac_stream_if.sv - multi-channel DAC driver: clock divider, stream FIFO, test patterns
// Data changes only on the edge that drives the DAC clock low.
module dac_stream_if #(
  parameter int DATA_W     = 14,
  parameter int NUM_CH     = 2,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int SQ_HALF    = 12
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [1:0]                   i_mode,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [NUM_CH*DATA_W-1:0]     i_data,
  input  logic                         i_clr,
  output logic                         o_dac_clk,
  output logic [NUM_CH*DATA_W-1:0]     o_dac_data,
  output logic [$clog2(FIFO_DEPTH):0]  o_level,
  output logic                         o_underflow
);

  localparam int W     = NUM_CH * DATA_W;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int SQ_W  = $clog2(SQ_HALF + 1);
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_STREAM = 2'd1,
    MODE_SQUARE = 2'd2,
    MODE_RAMP   = 2'd3
  } mode_t;

  logic [DIV_W-1:0]  div_ctr;
  logic              dac_clk;
  logic              div_last;
  logic              upd;

  mode_t             mode_r, mode_nxt;
  logic [SQ_W-1:0]   sq_cnt, sq_cnt_cur, sq_cnt_nxt;
  logic              sq_phase, sq_phase_cur, sq_phase_nxt;
  logic [DATA_W-1:0] ramp, ramp_cur, ramp_nxt;
  logic [DATA_W-1:0] sq_word;
  logic [W-1:0]      dac_data, data_nxt;
  logic              underflow, uf_set;

  logic [W-1:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic              push, pop;

  assign div_last = (div_ctr == DIV_W'(CLK_DIV - 1));
  assign upd      = div_last && dac_clk;

  // Ready comes only from the registered level, so a same-cycle pop never frees a slot.
  assign o_ready  = (level < LW'(FIFO_DEPTH)) && !i_rst;
  assign push     = i_valid && o_ready;

  always_comb begin
    mode_nxt     = mode_r;
    sq_cnt_cur   = sq_cnt;
    sq_phase_cur = sq_phase;
    ramp_cur     = ramp;
    sq_cnt_nxt   = sq_cnt;
    sq_phase_nxt = sq_phase;
    ramp_nxt     = ramp;
    sq_word      = '0;
    data_nxt     = dac_data;
    pop          = 1'b0;
    uf_set       = 1'b0;
    if (upd) begin
      mode_nxt = mode_t'(i_mode);
      // Entering a new mode restarts both patterns from their first sample.
      if (mode_nxt != mode_r) begin
        sq_cnt_cur   = '0;
        sq_phase_cur = 1'b0;
        ramp_cur     = '0;
      end
      sq_cnt_nxt   = sq_cnt_cur;
      sq_phase_nxt = sq_phase_cur;
      ramp_nxt     = ramp_cur;
      case (mode_nxt)
        MODE_IDLE: data_nxt = {NUM_CH{MID}};
        MODE_STREAM: begin
          if (level != '0) begin
            pop      = 1'b1;
            data_nxt = mem[rd_ptr];
          end else begin
            uf_set = 1'b1;
          end
        end
        MODE_SQUARE: begin
          sq_word  = {sq_phase_cur, {(DATA_W-1){1'b0}}};
          data_nxt = {NUM_CH{sq_word}};
          if (sq_cnt_cur == SQ_W'(SQ_HALF - 1)) begin
            sq_cnt_nxt   = '0;
            sq_phase_nxt = ~sq_phase_cur;
          end else begin
            sq_cnt_nxt = sq_cnt_cur + SQ_W'(1);
          end
        end
        MODE_RAMP: begin
          for (int k = 0; k < NUM_CH; k++) begin
            data_nxt[k*DATA_W +: DATA_W] = (k % 2 == 0) ? ramp_cur : ~ramp_cur;
          end
          ramp_nxt = ramp_cur + DATA_W'(1);
        end
        default: data_nxt = dac_data;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_ctr   <= '0;
      dac_clk   <= 1'b0;
      mode_r    <= MODE_IDLE;
      sq_cnt    <= '0;
      sq_phase  <= 1'b0;
      ramp      <= '0;
      dac_data  <= {NUM_CH{MID}};
      underflow <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
    end else begin
      div_ctr  <= div_last ? '0 : div_ctr + DIV_W'(1);
      if (div_last) dac_clk <= ~dac_clk;
      mode_r   <= mode_nxt;
      sq_cnt   <= sq_cnt_nxt;
      sq_phase <= sq_phase_nxt;
      ramp     <= ramp_nxt;
      dac_data <= data_nxt;
      if (i_clr) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        level     <= '0;
        underflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        level <= level + LW'(push) - LW'(pop);
        if (uf_set) underflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_clr) mem[wr_ptr] <= i_data;
  end

  assign o_dac_clk   = dac_clk;
  assign o_dac_data  = dac_data;
  assign o_level     = level;
  assign o_underflow = underflow;

endmodule

// File: tb/tb_dac_stream_if.sv
// tb/tb_dac_stream_if.sv - self-checking bench for dac_stream_if
// Queue-based reference model plus directed tables, loops and random traffic.
module tb_dac_stream_if;

  localparam int DATA_W     = 14;
  localparam int NUM_CH     = 2;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int SQ_HALF    = 12;
  localparam int W          = DATA_W * NUM_CH;
  localparam logic [W-1:0] MID2 = {2{14'h2000}};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic         valid = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] din = '0;
  logic         ready, dac_clk, uf;
  logic [W-1:0] dac_data;
  logic [3:0]   level;
  logic         r_clk, r_ready, r_uf;
  logic [W-1:0] r_data;
  logic [3:0]   r_level;

  always #5 clk = ~clk;

  dac_stream_if dut (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_valid(valid), .o_ready(ready),
    .i_data(din), .i_clr(clr), .o_dac_clk(dac_clk), .o_dac_data(dac_data),
    .o_level(level), .o_underflow(uf)
  );

  // Faster divider so the full 14-bit ramp wrap fits in the cycle budget.
  dac_stream_if #(.CLK_DIV(2)) dut_r (
    .i_clk(clk), .i_rst(rst), .i_mode(2'd3), .i_valid(1'b0), .o_ready(r_ready),
    .i_data({W{1'b0}}), .i_clr(1'b0), .o_dac_clk(r_clk), .o_dac_data(r_data),
    .o_level(r_level), .o_underflow(r_uf)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edges since reset release, updates since mode entry, FIFO as a queue.
  int           m_cyc;
  int           m_cnt;
  logic [1:0]   m_mode;
  logic [W-1:0] m_out;
  bit           m_uf;
  bit           m_upd;
  logic [W-1:0] m_q[$];

  task automatic model_reset();
    m_cyc = 0; m_cnt = 0; m_mode = 2'd0; m_out = MID2; m_uf = 0; m_upd = 0;
    m_q.delete();
  endtask

  task automatic model_eval();
    bit push;
    logic [DATA_W-1:0] r;
    push  = valid && (m_q.size() < FIFO_DEPTH);
    m_upd = ((m_cyc + 1) % (2 * CLK_DIV)) == 0;
    if (m_upd) begin
      if (mode != m_mode) m_cnt = 0;
      m_mode = mode;
      case (m_mode)
        2'd0: m_out = MID2;
        2'd1: if (m_q.size() > 0) m_out = m_q.pop_front(); else m_uf = 1;
        2'd2: m_out = (((m_cnt / SQ_HALF) % 2) != 0) ? MID2 : '0;
        default: begin
          r = DATA_W'(m_cnt);
          m_out = {~r, r};
        end
      endcase
      m_cnt++;
    end
    if (push) m_q.push_back(din);
    if (clr) begin
      m_q.delete();
      m_uf = 0;
    end
    m_cyc++;
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    chk("data", dac_data, m_out);
    chk("level", level, m_q.size());
    chk("ready", ready, m_q.size() < FIFO_DEPTH);
    chk("underflow", uf, m_uf);
    chk("dac_clk", dac_clk, (m_cyc / CLK_DIV) % 2);
  endtask

  task automatic run_to_upd();
    int n = 0;
    do begin
      step();
      n++;
    end while (!m_upd && n < 2 * CLK_DIV);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_ready", ready, 0);
    chk("rst_clk", dac_clk, 0);
    chk("rst_level", level, 0);
    chk("rst_uf", uf, 0);
    chk("rst_data", dac_data, MID2);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [1:0]   mode;
    logic         valid;
    logic [W-1:0] din;
    logic         clr;
    logic [W-1:0] exp_data;
    logic         exp_uf;
    int           exp_level;
  } vec_t;

  vec_t         vecs[4];
  logic [W-1:0] w[10];

  initial begin
    vecs[0] = '{2'd1, 1'b1, {14'h3ABC, 14'h0123}, 1'b0, {14'h3ABC, 14'h0123}, 1'b0, 0};
    vecs[1] = '{2'd1, 1'b1, {14'h1FFF, 14'h0001}, 1'b0, {14'h1FFF, 14'h0001}, 1'b0, 0};
    vecs[2] = '{2'd1, 1'b0, '0,                   1'b0, {14'h1FFF, 14'h0001}, 1'b1, 0};
    vecs[3] = '{2'd0, 1'b0, '0,                   1'b1, MID2,                 1'b0, 0};
    for (int i = 0; i < 10; i++) w[i] = {DATA_W'(16'h1000 + i), DATA_W'(16'h0200 + 7 * i)};

    #1;
    do_reset();

    // DAC clock: low for 4 edges, high for 4, period 8; idle output stays midscale.
    for (int c = 1; c <= 16; c++) begin
      step();
      chk("clk_seq", dac_clk, (c / 4) % 2);
      chk("idle_mid", dac_data, MID2);
    end

    for (int i = 0; i < 4; i++) begin
      mode = vecs[i].mode; valid = vecs[i].valid; din = vecs[i].din; clr = vecs[i].clr;
      step();
      valid = 1'b0; clr = 1'b0;
      if (!m_upd) run_to_upd();
      chk("vec_data", dac_data, vecs[i].exp_data);
      chk("vec_uf", uf, vecs[i].exp_uf);
      chk("vec_level", level, vecs[i].exp_level);
    end

    // Backpressure: 10 words offered in idle, only 8 fit.
    begin
      int acc = 0;
      mode = 2'd0;
      for (int i = 0; i < 10; i++) begin
        din = w[acc]; valid = 1'b1;
        if (ready) acc++;
        step();
      end
      chk("bp_accepted", acc, 8);
      chk("bp_level", level, 8);
      chk("bp_ready", ready, 0);
    end
    mode = 2'd1; din = w[8]; valid = 1'b1;
    run_to_upd();
    valid = 1'b0;
    chk("bp_first", dac_data, w[0]);
    chk("bp_refused", level, 7);
    for (int k = 1; k < 8; k++) begin
      run_to_upd();
      chk("bp_order", dac_data, w[k]);
      chk("bp_drain", level, 7 - k);
    end
    run_to_upd();
    chk("uf_set", uf, 1);
    chk("uf_hold", dac_data, w[7]);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("uf_clr", uf, 0);

    // Square wave, then leave and re-enter to confirm it restarts low.
    mode = 2'd2;
    for (int i = 0; i < 30; i++) begin
      run_to_upd();
      chk("square", dac_data, (((i / 12) % 2) != 0) ? MID2 : {W{1'b0}});
    end
    mode = 2'd0;
    run_to_upd();
    run_to_upd();
    mode = 2'd2;
    for (int i = 0; i < 14; i++) begin
      run_to_upd();
      chk("square_re", dac_data, (i >= 12) ? MID2 : {W{1'b0}});
    end

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      valid = ($urandom_range(0, 9) == 0);
      din   = {DATA_W'($urandom), DATA_W'($urandom)};
      clr   = ($urandom_range(0, 60) == 0);
      step();
    end
    valid = 1'b0; clr = 1'b0;

    // Async reset mid-stream with 3 words queued and underflow set.
    mode = 2'd0;
    run_to_upd();
    clr = 1'b1;
    step();
    clr = 1'b0;
    mode = 2'd1; din = w[9]; valid = 1'b1;
    step();
    valid = 1'b0;
    run_to_upd();
    chk("pre_word", dac_data, w[9]);
    run_to_upd();
    chk("pre_uf", uf, 1);
    for (int j = 0; j < 3; j++) begin
      din = w[j]; valid = 1'b1;
      step();
    end
    valid = 1'b0;
    step();
    step();
    chk("pre_level", level, 3);
    chk("pre_clk", dac_clk, 1);
    do_reset();

    // Ramp on the fast-divider instance: full wrap, odd channel inverted.
    for (int n = 0; n < 16390; n++) begin
      logic [DATA_W-1:0] r;
      repeat (2 * 2) @(posedge clk);
      #1;
      r = DATA_W'(n);
      chk("ramp", r_data, {~r, r});
      if (n % 4096 == 0) chk("ramp_clk", r_clk, 0);
    end
    chk("ramp_level", r_level, 0);
    chk("ramp_ready", r_ready, 1);
    chk("ramp_uf", r_uf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_stream_if.md
Name: dac_stream_if

Overview:
- Parametrised successor to the single-channel AD9767 pattern driver.
- Generates the DAC sample clock from i_clk by an integer divider. Drives NUM_CH parallel DAC data buses that change only on the falling DAC-clock edge.
- Selects per-mode sources: midscale idle, streamed samples from an internal FIFO fed by a valid/ready port, square-wave test pattern, or ramp test pattern.
- Sits between the sample-generation logic and the DAC pins, with underflow and level status for the control logic.

Parameters:
- DATA_W, 14, DAC sample width per channel (≥4).
- NUM_CH, 2, number of DAC channels driven in parallel (≥1).
- CLK_DIV, 4, i_clk cycles per DAC-clock half period (≥2). DAC clock = i_clk / (2*CLK_DIV).
- FIFO_DEPTH, 8, stream FIFO depth in NUM_CH-sample words (power of 2, ≥2).
- SQ_HALF, 12, DAC updates per square-wave half period (≥1).

Ports:
- i_clk, in, 1, system clock; all logic on posedge.
- i_rst, in, 1, reset, asynchronous, active-high.
- i_mode, in, 2, 0 = idle midscale, 1 = stream, 2 = square, 3 = ramp.
- i_valid, in, 1, input word valid.
- o_ready, out, 1, FIFO can accept a word.
- i_data, in, NUM_CH*DATA_W, input word; channel k in bits [k*DATA_W +: DATA_W].
- i_clr, in, 1, synchronous flush of FIFO and clear of o_underflow.
- o_dac_clk, out, 1, DAC sample clock.
- o_dac_data, out, NUM_CH*DATA_W, DAC data, channel packing as i_data.
- o_level, out, $clog2(FIFO_DEPTH)+1, FIFO occupancy.
- o_underflow, out, 1, sticky stream underflow flag.

Behaviour:
- Reset (async assert, any time, including mid-transfer):
  - div_ctr = 0, o_dac_clk = 0.
  - FIFO empty, o_level = 0, o_ready = 0 during reset.
  - o_underflow = 0.
  - Every channel of o_dac_data = midscale, i.e. 1 << (DATA_W-1).
  - Active mode register = 0; square and ramp state = 0.
- Divider:
  - div_ctr counts 0..CLK_DIV-1 and wraps.
  - On the cycle with div_ctr == CLK_DIV-1, o_dac_clk toggles.
- Update strobe (upd): div_ctr == CLK_DIV-1 and o_dac_clk == 1, i.e. the edge that drives o_dac_clk low.
  - o_dac_data changes only on upd edges, so data is stable for CLK_DIV i_clk cycles before each DAC rising edge.
  - First upd is the edge 2*CLK_DIV-1 cycles after reset release.
- Mode:
  - i_mode is sampled only on upd into the active mode register; the new value takes effect in that same update.
  - A change of active mode zeroes the square and ramp state before computing the output.
- Idle (0): all channels = midscale.
- Stream (1):
  - On upd, if the FIFO is non-empty: pop the head word and drive it to o_dac_data. Latency from the accepting edge on an empty FIFO to the pin is the next upd.
  - On upd with the FIFO empty: hold o_dac_data and set o_underflow.
- Square (2):
  - Lower DATA_W-1 bits = 0.
  - MSB = sq_phase, identical on all channels.
  - sq_cnt counts upd events 0..SQ_HALF-1; at wrap sq_phase inverts.
  - First SQ_HALF updates output 0; the next SQ_HALF output 1 << (DATA_W-1).
- Ramp (3):
  - ramp register increments by 1 per upd, wrapping from 2^DATA_W-1 to 0.
  - First output after entry is 0.
  - Channel k = ramp for even k, ~ramp for odd k.
- FIFO:
  - o_ready = (o_level < FIFO_DEPTH) and not i_rst, combinational from the registered level.
  - A word is accepted when i_valid && o_ready.
  - Push while full is not possible.
  - Simultaneous push and pop: level unchanged, order preserved. A pop never frees space for a push in the same cycle.
  - Outside stream mode the FIFO keeps accepting until full; nothing is popped.
- i_clr:
  - Empties the FIFO (a push that cycle is discarded) and clears o_underflow.
  - Underflow-set in the same cycle loses to clear.
  - Outputs and divider are unaffected.
- Widths: all arithmetic is modulo 2^DATA_W; no saturation.

Test Plan:
- Reset timing (CLK_DIV = 4): release reset → o_dac_clk period 8 i_clk; o_dac_data = 0x2000 on both channels; first upd at cycle 7 after release.
- Stream: push {0x0123, 0x3ABC}, {0x0001, 0x1FFF} back-to-back in mode 1 → pins show the words in order on consecutive upd, stable for 4 i_clk before each DAC rising edge. Third upd → data held, o_underflow = 1; pulse i_clr → 0.
- Backpressure: hold i_valid in mode 0 with 10 distinct words → exactly 8 accepted, o_ready low, o_level = 8. Switch to mode 1 → 8 words emerge in order and o_level decrements per upd. A push on the same cycle as a pop while full is refused.
- Square (SQ_HALF = 12): mode 2 → 12 updates of 0x0000, then 12 of 0x2000, repeating. Switching out and back to mode 2 restarts at 0x0000.
- Ramp: mode 3 from reset, run 16390 upd → ch0 goes 0..0x3FFF, wraps to 0; ch1 = ~ch0 (0x3FFF at start).
- Async reset asserted mid-stream with 3 words queued → outputs immediately midscale, o_dac_clk = 0, o_level = 0, o_underflow = 0 without waiting for a clock edge.
